trigger_engine: RTL and testbench

Parametrised, fully synchronous successor to the per-instrument trade triggerer. It holds NUM_SLOTS independently configured trigger slots. Each slot compares the normalised trade stream against buy/sell price and size limits and emits a one-cycle fire pulse. It sits between the market-data decoder (trade stream) and the order-entry block (consumes fire). Unlike its predecessor, it adds runtime config writes, explicit arm/disarm, and one-shot, re-arm-with-holdoff and N-hit modes.

---
 rtl/trig_pkg.sv | 54 +++++
 rtl/trig_slot.sv | 110 +++++++++++
 rtl/trigger_engine.sv | 85 ++++++++
 tb/tb_trigger_engine.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trig_pkg.sv
// Shared types and widths for the trade trigger engine.
package trig_pkg;

  localparam int unsigned TRIG_SECID_W = 32;
  localparam int unsigned TRIG_PRICE_W = 64;
  localparam int unsigned TRIG_SIZE_W  = 32;
  localparam int unsigned TRIG_CNT_W   = 8;
  localparam int unsigned TRIG_HOLD_W  = 16;

  localparam logic [1:0] SIDE_BUY  = 2'd1;
  localparam logic [1:0] SIDE_SELL = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_FIRED   = 2'd2,
    ST_HOLDOFF = 2'd3
  } slot_state_t;

  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'd0,
    MODE_REARM   = 2'd1,
    MODE_COUNT   = 2'd2
  } trig_mode_t;

  typedef struct packed {
    logic [TRIG_SECID_W-1:0] secid;
    logic [TRIG_PRICE_W-1:0] buy_px;
    logic [TRIG_PRICE_W-1:0] sell_px;
    logic [TRIG_SIZE_W-1:0]  buy_sz;
    logic [TRIG_SIZE_W-1:0]  sell_sz;
    trig_mode_t              mode;
    logic [TRIG_CNT_W-1:0]   hits;
    logic [TRIG_HOLD_W-1:0]  holdoff;
  } trig_cfg_t;

  typedef struct packed {
    logic                    valid;
    logic [TRIG_SECID_W-1:0] secid;
    logic [TRIG_PRICE_W-1:0] price;
    logic [TRIG_SIZE_W-1:0]  size;
    logic [1:0]              side;
  } trig_trade_t;

  // Reserved encoding 3 collapses to ONESHOT at write time.
  function automatic trig_mode_t decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_REARM;
      2'd2:    return MODE_COUNT;
      default: return MODE_ONESHOT;
    endcase
  endfunction

endpackage

// File: rtl/trig_slot.sv
// One trigger slot: config storage, trade match, arm/fire FSM and counters.
module trig_slot
  import trig_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cfg_wr,
  input  trig_cfg_t   i_cfg,
  input  logic        i_arm,
  input  logic        i_disarm,
  input  trig_trade_t i_trade,
  output logic        o_fire,
  output logic [1:0]  o_state
);

  trig_cfg_t              r_cfg;
  slot_state_t            r_state;
  logic [TRIG_CNT_W-1:0]  r_hits;
  logic [TRIG_HOLD_W-1:0] r_hold;
  logic                   r_fire;

  slot_state_t            w_state_nxt;
  logic [TRIG_CNT_W-1:0]  w_hits_nxt;
  logic [TRIG_HOLD_W-1:0] w_hold_nxt;
  logic                   w_fire_nxt;
  logic                   w_match;
  logic [TRIG_CNT_W-1:0]  w_cnt_inc;
  logic [TRIG_CNT_W-1:0]  w_target;

  assign w_match = i_trade.valid && (i_trade.secid == r_cfg.secid) &&
                   (((i_trade.side == SIDE_BUY) &&
                     (i_trade.price >= r_cfg.buy_px) && (i_trade.size >= r_cfg.buy_sz)) ||
                    ((i_trade.side == SIDE_SELL) &&
                     (i_trade.price <= r_cfg.sell_px) && (i_trade.size >= r_cfg.sell_sz)));

  assign w_cnt_inc = (&r_hits) ? r_hits : r_hits + 1'b1;
  assign w_target  = ((r_cfg.mode == MODE_COUNT) && (r_hits != r_hits + 1'b1) &&
                      (r_cfg.hits != '0)) ? r_cfg.hits : TRIG_CNT_W'(1);

  // State, counters, fire pulse and config registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg   <= '0;
      r_state <= ST_IDLE;
      r_hits  <= '0;
      r_hold  <= '0;
      r_fire  <= 1'b0;
    end else begin
      if (i_cfg_wr) begin
        r_cfg <= i_cfg;
      end
      r_state <= w_state_nxt;
      r_hits  <= w_hits_nxt;
      r_hold  <= w_hold_nxt;
      r_fire  <= w_fire_nxt;
    end
  end

  // Next state in priority order: config write, disarm, arm, then match/holdoff.
  always_comb begin
    w_state_nxt = r_state;
    w_hits_nxt  = r_hits;
    w_hold_nxt  = r_hold;
    w_fire_nxt  = 1'b0;
    if (i_cfg_wr) begin
      w_state_nxt = ST_IDLE;
      w_hits_nxt  = '0;
      w_hold_nxt  = '0;
    end else if (i_disarm) begin
      w_state_nxt = ST_IDLE;
    end else if (i_arm && (r_state != ST_HOLDOFF)) begin
      // Re-arming an armed slot restarts the hit count; any match this cycle is dropped.
      w_state_nxt = ST_ARMED;
      w_hits_nxt  = '0;
    end else begin
      case (r_state)
        ST_ARMED: begin
          if (w_match) begin
            w_hits_nxt = w_cnt_inc;
            if (w_cnt_inc >= w_target) begin
              w_fire_nxt = 1'b1;
              if (r_cfg.mode == MODE_REARM) begin
                w_state_nxt = ST_HOLDOFF;
                w_hold_nxt  = r_cfg.holdoff;
              end else begin
                w_state_nxt = ST_FIRED;
              end
            end
          end
        end
        ST_HOLDOFF: begin
          // Holdoff N keeps the slot dead for N cycles (at least one).
          if (r_hold <= TRIG_HOLD_W'(1)) begin
            w_state_nxt = ST_ARMED;
            w_hold_nxt  = '0;
            w_hits_nxt  = '0;
          end else begin
            w_hold_nxt = r_hold - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_fire  = r_fire;
  assign o_state = r_state;

endmodule

// File: rtl/trigger_engine.sv
// Multi-slot trade trigger: registers the trade stream and fans it out to slots.
module trigger_engine
  import trig_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 8,
  parameter int unsigned SECID_W   = TRIG_SECID_W,
  parameter int unsigned PRICE_W   = TRIG_PRICE_W,
  parameter int unsigned SIZE_W    = TRIG_SIZE_W,
  parameter int unsigned CNT_W     = TRIG_CNT_W,
  parameter int unsigned HOLD_W    = TRIG_HOLD_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_wr,
  input  logic [$clog2(NUM_SLOTS)-1:0] cfg_slot,
  input  logic [SECID_W-1:0]           cfg_secid,
  input  logic [PRICE_W-1:0]           cfg_buy_px,
  input  logic [PRICE_W-1:0]           cfg_sell_px,
  input  logic [SIZE_W-1:0]            cfg_buy_sz,
  input  logic [SIZE_W-1:0]            cfg_sell_sz,
  input  logic [1:0]                   cfg_mode,
  input  logic [CNT_W-1:0]             cfg_hits,
  input  logic [HOLD_W-1:0]            cfg_holdoff,
  input  logic [NUM_SLOTS-1:0]         arm,
  input  logic [NUM_SLOTS-1:0]         disarm,
  input  logic                         trade_valid,
  input  logic [SECID_W-1:0]           trade_secid,
  input  logic [PRICE_W-1:0]           trade_price,
  input  logic [SIZE_W-1:0]            trade_size,
  input  logic [1:0]                   trade_side,
  output logic [NUM_SLOTS-1:0]         fire,
  output logic                         fire_any,
  output logic [2*NUM_SLOTS-1:0]       slot_state
);

  trig_trade_t          r_trade;
  trig_cfg_t            w_cfg;
  logic [NUM_SLOTS-1:0] w_cfg_sel;

  // S1: capture the incoming trade beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_trade <= '0;
    end else begin
      r_trade.valid <= trade_valid;
      r_trade.secid <= TRIG_SECID_W'(trade_secid);
      r_trade.price <= TRIG_PRICE_W'(trade_price);
      r_trade.size  <= TRIG_SIZE_W'(trade_size);
      r_trade.side  <= trade_side;
    end
  end

  // Assemble the config word broadcast to every slot.
  always_comb begin
    w_cfg         = '0;
    w_cfg.secid   = TRIG_SECID_W'(cfg_secid);
    w_cfg.buy_px  = TRIG_PRICE_W'(cfg_buy_px);
    w_cfg.sell_px = TRIG_PRICE_W'(cfg_sell_px);
    w_cfg.buy_sz  = TRIG_SIZE_W'(cfg_buy_sz);
    w_cfg.sell_sz = TRIG_SIZE_W'(cfg_sell_sz);
    w_cfg.mode    = decode_mode(cfg_mode);
    w_cfg.hits    = TRIG_CNT_W'(cfg_hits);
    w_cfg.holdoff = TRIG_HOLD_W'(cfg_holdoff);
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    // Out-of-range slot numbers select nothing.
    assign w_cfg_sel[g] = cfg_wr && (32'(cfg_slot) == g);

    trig_slot u_slot (
      .clk      (clk),
      .rst      (rst),
      .i_cfg_wr (w_cfg_sel[g]),
      .i_cfg    (w_cfg),
      .i_arm    (arm[g]),
      .i_disarm (disarm[g]),
      .i_trade  (r_trade),
      .o_fire   (fire[g]),
      .o_state  (slot_state[2*g +: 2])
    );
  end

  assign fire_any = |fire;

endmodule

// File: tb/tb_trigger_engine.sv
module tb_trigger_engine;

  localparam int unsigned NS = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_wr;
  logic [2:0]    cfg_slot;
  logic [31:0]   cfg_secid;
  logic [63:0]   cfg_buy_px;
  logic [63:0]   cfg_sell_px;
  logic [31:0]   cfg_buy_sz;
  logic [31:0]   cfg_sell_sz;
  logic [1:0]    cfg_mode;
  logic [7:0]    cfg_hits;
  logic [15:0]   cfg_holdoff;
  logic [NS-1:0] arm;
  logic [NS-1:0] disarm;
  logic          trade_valid;
  logic [31:0]   trade_secid;
  logic [63:0]   trade_price;
  logic [31:0]   trade_size;
  logic [1:0]    trade_side;
  logic [NS-1:0] fire;
  logic          fire_any;
  logic [2*NS-1:0] slot_state;

  trigger_engine #(.NUM_SLOTS(NS)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_wr      (cfg_wr),
    .cfg_slot    (cfg_slot),
    .cfg_secid   (cfg_secid),
    .cfg_buy_px  (cfg_buy_px),
    .cfg_sell_px (cfg_sell_px),
    .cfg_buy_sz  (cfg_buy_sz),
    .cfg_sell_sz (cfg_sell_sz),
    .cfg_mode    (cfg_mode),
    .cfg_hits    (cfg_hits),
    .cfg_holdoff (cfg_holdoff),
    .arm         (arm),
    .disarm      (disarm),
    .trade_valid (trade_valid),
    .trade_secid (trade_secid),
    .trade_price (trade_price),
    .trade_size  (trade_size),
    .trade_side  (trade_side),
    .fire        (fire),
    .fire_any    (fire_any),
    .slot_state  (slot_state)
  );

  always #5 clk = ~clk;

  int unsigned   n_vec = 0;
  int unsigned   n_err = 0;
  logic [NS-1:0] exp_q[$];

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input int s, input logic [1:0] e, input string tag);
    check(tag, 64'(slot_state[2*s +: 2]), 64'(e));
  endtask

  // Push the fire vector this cycle's inputs must produce two cycles on,
  // clock once, then compare the fire vector now due.
  task automatic step(input logic [NS-1:0] exp_fire, input string tag);
    logic [NS-1:0] e;
    exp_q.push_back(exp_fire);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, "/fire"}, 64'(fire), 64'(e));
    check({tag, "/any"}, 64'(fire_any), 64'(|e));
    cfg_wr      = 1'b0;
    arm         = '0;
    disarm      = '0;
    trade_valid = 1'b0;
  endtask

  task automatic set_cfg(input logic [2:0] slot, input logic [31:0] secid,
                         input logic [63:0] bpx, input logic [63:0] spx,
                         input logic [31:0] bsz, input logic [31:0] ssz,
                         input logic [1:0] mode, input logic [7:0] hits,
                         input logic [15:0] hold);
    cfg_wr      = 1'b1;
    cfg_slot    = slot;
    cfg_secid   = secid;
    cfg_buy_px  = bpx;
    cfg_sell_px = spx;
    cfg_buy_sz  = bsz;
    cfg_sell_sz = ssz;
    cfg_mode    = mode;
    cfg_hits    = hits;
    cfg_holdoff = hold;
  endtask

  task automatic set_trade(input logic [31:0] secid, input logic [63:0] px,
                           input logic [31:0] sz, input logic [1:0] side);
    trade_valid = 1'b1;
    trade_secid = secid;
    trade_price = px;
    trade_size  = sz;
    trade_side  = side;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cfg_wr = 1'b0; cfg_slot = '0; cfg_secid = '0;
    cfg_buy_px = '0; cfg_sell_px = '0; cfg_buy_sz = '0; cfg_sell_sz = '0;
    cfg_mode = '0; cfg_hits = '0; cfg_holdoff = '0; arm = '0; disarm = '0;
    trade_valid = 1'b0; trade_secid = '0; trade_price = '0; trade_size = '0;
    trade_side = '0;
    exp_q.push_back('0);

    step('0, "rst0");
    step('0, "rst1");
    rst = 1'b0;
    check("rst/state", 64'(slot_state), 64'(0));
    check("rst/fire", 64'(fire), 64'(0));

    // ONESHOT buy side on slot 0
    set_cfg(3'd0, 32'd7, 64'd100, 64'd0, 32'd10, 32'd0, 2'd0, 8'd0, 16'd0);
    step('0, "os/cfg");
    arm = 8'h01; step('0, "os/arm");
    chk_st(0, 2'd1, "os/armed");
    set_trade(32'd7, 64'd101, 32'd10, 2'd1); step(8'h01, "os/t1");
    set_trade(32'd7, 64'd101, 32'd10, 2'd1); step(8'h00, "os/t2");
    step('0, "os/f1");
    step('0, "os/f2");
    chk_st(0, 2'd2, "os/fired");

    // Sell side on slot 1, with ignored sides and foreign secid
    set_cfg(3'd1, 32'd7, ONES, 64'd50, 32'hFFFF_FFFF, 32'd5, 2'd0, 8'd0, 16'd0);
    step('0, "sl/cfg");
    arm = 8'h02; step('0, "sl/arm");
    set_trade(32'd7, 64'd50, 32'd4, 2'd2); step(8'h00, "sl/small");
    set_trade(32'd7, 64'd40, 32'd9, 2'd0); step(8'h00, "sl/side0");
    set_trade(32'd7, 64'd40, 32'd9, 2'd3); step(8'h00, "sl/side3");
    set_trade(32'd8, 64'd40, 32'd9, 2'd2); step(8'h00, "sl/secid8");
    set_trade(32'd7, 64'd49, 32'd5, 2'd2); step(8'h02, "sl/hit");
    step('0, "sl/f1");
    step('0, "sl/f2");
    chk_st(1, 2'd2, "sl/fired");

    // REARM with holdoff 3 on slot 2
    set_cfg(3'd2, 32'd9, 64'd100, 64'd0, 32'd1, 32'hFFFF_FFFF, 2'd1, 8'd0, 16'd3);
    step('0, "ra/cfg");
    arm = 8'h04; step('0, "ra/arm");
    set_trade(32'd9, 64'd200, 32'd5, 2'd1); step(8'h04, "ra/t0");
    set_trade(32'd9, 64'd200, 32'd5, 2'd1); step(8'h00, "ra/t1");
    chk_st(2, 2'd3, "ra/holdoff");
    set_trade(32'd9, 64'd200, 32'd5, 2'd1); step(8'h00, "ra/t2");
    set_trade(32'd9, 64'd200, 32'd5, 2'd1); step(8'h00, "ra/t3");
    chk_st(2, 2'd3, "ra/holdoff3");
    set_trade(32'd9, 64'd200, 32'd5, 2'd1); step(8'h04, "ra/t4");
    chk_st(2, 2'd1, "ra/rearmed");
    for (int i = 0; i < 5; i++) step('0, "ra/idle");
    chk_st(2, 2'd1, "ra/armed_again");

    // REARM with holdoff 0: every other qualifying cycle fires
    set_cfg(3'd2, 32'd9, 64'd100, 64'd0, 32'd1, 32'hFFFF_FFFF, 2'd1, 8'd0, 16'd0);
    step('0, "h0/cfg");
    arm = 8'h04; step('0, "h0/arm");
    set_trade(32'd9, 64'd200, 32'd5, 2'd1); step(8'h04, "h0/t0");
    set_trade(32'd9, 64'd200, 32'd5, 2'd1); step(8'h00, "h0/t1");
    set_trade(32'd9, 64'd200, 32'd5, 2'd1); step(8'h04, "h0/t2");
    set_trade(32'd9, 64'd200, 32'd5, 2'd1); step(8'h00, "h0/t3");
    for (int i = 0; i < 3; i++) step('0, "h0/idle");
    chk_st(2, 2'd1, "h0/armed");

    // COUNT with hits 3 on slot 3
    set_cfg(3'd3, 32'd11, 64'd10, 64'd0, 32'd1, 32'hFFFF_FFFF, 2'd2, 8'd3, 16'd0);
    step('0, "ct/cfg");
    arm = 8'h08; step('0, "ct/arm");
    set_trade(32'd11, 64'd10, 32'd1, 2'd1); step(8'h00, "ct/t0");
    set_trade(32'd11, 64'd10, 32'd1, 2'd1); step(8'h00, "ct/t1");
    set_trade(32'd11, 64'd10, 32'd1, 2'd1); step(8'h08, "ct/t2");
    set_trade(32'd11, 64'd10, 32'd1, 2'd1); step(8'h00, "ct/t3");
    set_trade(32'd11, 64'd10, 32'd1, 2'd1); step(8'h00, "ct/t4");
    step('0, "ct/f1");
    step('0, "ct/f2");
    chk_st(3, 2'd2, "ct/fired");

    // COUNT with hits 0 behaves as hits 1
    set_cfg(3'd3, 32'd11, 64'd10, 64'd0, 32'd1, 32'hFFFF_FFFF, 2'd2, 8'd0, 16'd0);
    step('0, "c0/cfg");
    arm = 8'h08; step('0, "c0/arm");
    set_trade(32'd11, 64'd10, 32'd1, 2'd1); step(8'h08, "c0/t0");
    step('0, "c0/f1");
    step('0, "c0/f2");
    chk_st(3, 2'd2, "c0/fired");

    // Buy-side boundaries on slot 4
    set_cfg(3'd4, 32'd20, 64'd100, 64'd0, 32'd10, 32'hFFFF_FFFF, 2'd0, 8'd0, 16'd0);
    step('0, "bd/cfg");
    arm = 8'h10; step('0, "bd/arm");
    set_trade(32'd20, 64'd99, 32'd10, 2'd1); step(8'h00, "bd/px99");
    set_trade(32'd20, 64'd100, 32'd9, 2'd1); step(8'h00, "bd/sz9");
    set_trade(32'd20, 64'd100, 32'd10, 2'd1); step(8'h10, "bd/exact");
    step('0, "bd/f1");
    step('0, "bd/f2");

    // Arm while armed drops the concurrent match and restarts the count
    set_cfg(3'd5, 32'd13, 64'd10, 64'd0, 32'd1, 32'hFFFF_FFFF, 2'd2, 8'd2, 16'd0);
    step('0, "aa/cfg");
    arm = 8'h20; step('0, "aa/arm");
    set_trade(32'd13, 64'd10, 32'd1, 2'd1); step(8'h00, "aa/tA");
    set_trade(32'd13, 64'd10, 32'd1, 2'd1); arm = 8'h20; step(8'h00, "aa/tB");
    set_trade(32'd13, 64'd10, 32'd1, 2'd1); step(8'h20, "aa/tC");
    step('0, "aa/f1");
    step('0, "aa/f2");
    chk_st(5, 2'd2, "aa/fired");

    // Config write to slot 2 while its matching trade sits in S1
    set_trade(32'd9, 64'd200, 32'd5, 2'd1); step(8'h00, "cw/trade");
    set_cfg(3'd2, 32'd9, 64'd100, 64'd0, 32'd1, 32'hFFFF_FFFF, 2'd0, 8'd0, 16'd0);
    step('0, "cw/cfg");
    step('0, "cw/f1");
    step('0, "cw/f2");
    chk_st(2, 2'd0, "cw/idle");

    // Arm and disarm together
    arm = 8'h04; step('0, "ad/arm");
    chk_st(2, 2'd1, "ad/armed");
    arm = 8'h04; disarm = 8'h04; step('0, "ad/both");
    chk_st(2, 2'd0, "ad/idle");

    // Reset mid-HOLDOFF with a trade in S1
    set_cfg(3'd6, 32'd15, 64'd100, 64'd0, 32'd1, 32'hFFFF_FFFF, 2'd1, 8'd0, 16'd10);
    step('0, "rh/cfg");
    arm = 8'h40; step('0, "rh/arm");
    set_trade(32'd15, 64'd100, 32'd1, 2'd1); step(8'h40, "rh/tA");
    step('0, "rh/idle");
    chk_st(6, 2'd3, "rh/holdoff");
    set_trade(32'd15, 64'd100, 32'd1, 2'd1); step(8'h00, "rh/tB");
    rst = 1'b1; step('0, "rh/rst");
    rst = 1'b0;
    check("rh/state", 64'(slot_state), 64'(0));
    check("rh/fire", 64'(fire), 64'(0));
    arm = 8'h40; step('0, "rh/rearm");
    chk_st(6, 2'd1, "rh/armed");
    set_trade(32'd15, 64'd500, 32'd50, 2'd1); step(8'h00, "rh/oldcfg");
    set_trade(32'd0, 64'd0, 32'd0, 2'd1); step(8'h40, "rh/zerocfg");
    step('0, "rh/f1");
    step('0, "rh/f2");
    chk_st(6, 2'd2, "rh/fired");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
